dsp_mac_sequencer: RTL
======================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 Parameter LEN_W, default 16, sets the width of the beat-count field.
REQ-002 Parameter PIPE_LAT, default 3, is the DSP latency in cycles from operand capture to a valid P (A1/B1 reg, M reg, P reg); fixed at 3 for this revision.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a dot product; sampled only in IDLE.
REQ-006 len  in  LEN_W  number of operand beats, unsigned; sampled with start.
REQ-007 abort  in  1  cancels the operation in progress.
REQ-008 in_valid / in_ready  in / out  1 / 1  operand-beat handshake; a beat transfers when both are high.
REQ-009 in_a, in_b  in  18 each  signed operands for the beat.
REQ-010 dsp_a, dsp_b  out  18 each  combinational pass-through of in_a and in_b.
REQ-011 dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ce_opmode  out  1 each  DSP clock enables.
REQ-012 dsp_opmode  out  8  DSP OPMODE word.
REQ-013 dsp_rst  out  1  active-high synchronous clear driven to all DSP register resets.
REQ-014 dsp_p  in  48  DSP P output.
REQ-015 busy, done, err  out  1 each  status outputs; done and err are single-cycle pulses.
REQ-016 result  out  48  captured accumulation; holds its value until the next done.

Function
REQ-017 The FSM SHALL have the states IDLE, CLR, RUN, DRAIN and DONE.
REQ-018 In IDLE, start with len!=0 SHALL load the beat counter with len and go to CLR; start with len==0 SHALL pulse err for one cycle and stay in IDLE.
REQ-019 CLR SHALL last one cycle and assert dsp_rst; the next state is RUN.
REQ-020 in_ready SHALL be high only in RUN while the beat counter is nonzero.
REQ-021 On a transfer in cycle t, dsp_cea and dsp_ceb SHALL be high in cycle t, and the counter SHALL decrement.
REQ-022 dsp_cea and dsp_ceb SHALL be low in every cycle without a transfer, so input bubbles are legal and never accumulate.
REQ-023 A 2-deep valid/first-tag shift pipeline SHALL produce: dsp_cem and dsp_ce_opmode high in cycle t+1, and dsp_cep high in cycle t+2.
REQ-024 In cycle t+1, dsp_opmode SHALL be 8'h01 (X=M, Z=0) for the first beat of an operation and 8'h09 (X=M, Z=P) for every later beat; in all other cycles it SHALL hold its last value.
REQ-025 When the counter reaches 0, the FSM SHALL go to DRAIN.
REQ-026 DRAIN SHALL wait until the pipeline is empty, then capture dsp_p into result in the cycle after the last dsp_cep (that is, t_last+3) and go to DONE.
REQ-027 DONE SHALL pulse done for one cycle, with result already valid, then return to IDLE.
REQ-028 The accumulation is signed 18x18 products summed in 48 bits, with wrap-around on overflow; no saturation.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 start SHALL be ignored while busy.
REQ-031 abort in CLR, RUN or DRAIN SHALL, on the next cycle: assert dsp_rst for one cycle, clear the pipeline and counter, drop in_ready, enter IDLE, and leave result unchanged with no done pulse.
REQ-032 abort and start in the same cycle in IDLE: start wins, since abort has no effect in IDLE.
REQ-033 If abort and the final transfer occur in the same cycle, abort wins.

Reset
REQ-034 While rst_n is low, the block SHALL be in IDLE and every output SHALL be 0: in_ready, all enables, dsp_opmode=8'h00, dsp_rst, busy, done, err and result.
REQ-035 The pipeline and counter SHALL clear asynchronously on reset.
REQ-036 Reset assertion mid-operation SHALL discard the operation with no done pulse.
REQ-037 Deassertion of rst_n SHALL be synchronised internally, with a 2-flop release.

Verification
REQ-038 len=4, beats (1,2),(3,4),(5,6),(7,8) back-to-back, DSP model attached -> done exactly 4 cycles after the last transfer, result=100.
REQ-039 Same beats with in_valid low for 2 cycles between each beat -> result=100; CEA/CEB/CEM/CEP each pulse exactly 4 times.
REQ-040 len=2, beats (-3,5),(2,2) -> result=48'hFFFF_FFFF_FFF5 (-11); opmode sequence observed 01 then 09.
REQ-041 len=0 with start -> err pulses one cycle, busy stays 0, no DSP enables.
REQ-042 len=8, abort after 3 transfers -> dsp_rst for one cycle, IDLE next, no done, result keeps its prior value; a following len=1 run of (4,4) gives result=16.
REQ-043 rst_n low during DRAIN -> all outputs 0 immediately; no done after release.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: sequences operand beats through a 3-stage DSP MAC and captures the dot product
module dsp_mac_sequencer #(
  parameter int LEN_W    = 16,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [17:0]       in_a,
  input  logic [17:0]       in_b,
  output logic [17:0]       dsp_a,
  output logic [17:0]       dsp_b,
  output logic              dsp_cea,
  output logic              dsp_ceb,
  output logic              dsp_cem,
  output logic              dsp_cep,
  output logic              dsp_ce_opmode,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_rst,
  input  logic [47:0]       dsp_p,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [47:0]       result
);
  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;
  state_t              state;
  logic [1:0]          rs;
  logic                rst_i_n;
  logic [LEN_W-1:0]    cnt;
  logic [PIPE_LAT-2:0] vp;
  logic                first;
  logic                xfer;
  assign rst_i_n       = rs[1];
  assign in_ready      = (state == RUN) && (cnt != '0);
  assign xfer          = in_ready && in_valid;
  assign dsp_a         = in_a;
  assign dsp_b         = in_b;
  assign dsp_cea       = xfer;
  assign dsp_ceb       = xfer;
  assign dsp_cem       = vp[0];
  assign dsp_ce_opmode = vp[0];
  assign dsp_cep       = vp[PIPE_LAT-2];
  assign busy          = state != IDLE;
  // reset asserts immediately and releases through two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rs <= 2'b00;
    else rs <= {rs[0], 1'b1};
  end
  // control FSM; the valid shift register tracks beats through the M and P stages
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state      <= IDLE;
      cnt        <= '0;
      vp         <= '0;
      first      <= 1'b0;
      dsp_opmode <= 8'h00;
      dsp_rst    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
    end else if (abort && (state == CLR || state == RUN || state == DRAIN)) begin
      state   <= IDLE;
      cnt     <= '0;
      vp      <= '0;
      dsp_rst <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      dsp_rst <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      vp      <= (vp << 1) | (PIPE_LAT-1)'(xfer);
      if (xfer) begin
        cnt        <= cnt - 1'b1;
        first      <= 1'b0;
        dsp_opmode <= first ? 8'h01 : 8'h09;
      end
      case (state)
        IDLE:
          if (start) begin
            if (len == '0) err <= 1'b1;
            else begin
              cnt     <= len;
              first   <= 1'b1;
              dsp_rst <= 1'b1;
              state   <= CLR;
            end
          end
        CLR:   state <= RUN;
        RUN:   if (xfer && cnt == LEN_W'(1)) state <= DRAIN;
        DRAIN:
          if (vp == '0) begin
            result <= dsp_p;
            done   <= 1'b1;
            state  <= DONE;
          end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
